// File: rtl/hex_uart_tx.sv
// hex_uart_tx: latches a 4-nibble word, sends each nibble as an uppercase ASCII hex
// character over an 8N1 UART line (digit1 first), and can append CR LF after the digits.
// o_tx_busy stays high from the cycle after acceptance until the last stop bit completes.
module hex_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter bit          SEND_CRLF    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_tx_data1,
    input  logic [3:0] i_tx_data2,
    input  logic [3:0] i_tx_data3,
    input  logic [3:0] i_tx_data4,
    input  logic       i_tx_valid,
    output logic       o_tx_busy,
    output logic       o_uart_tx
);

    // Keep the baud counter at least 1 bit wide so CLKS_PER_BIT=1 still elaborates.
    localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_CHAR = SEND_CRLF ? 3'd5 : 3'd3;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            r_state, w_state_next;
    logic [BAUD_W-1:0] r_baud_cnt, w_baud_cnt_next;
    logic [2:0]        r_bit_idx, w_bit_idx_next;
    logic [2:0]        r_char_idx, w_char_idx_next;
    logic [15:0]       r_data, w_data_next;
    logic              r_tx, w_tx_next;
    logic              r_busy, w_busy_next;

    logic [7:0]        w_cur_char;
    logic [2:0]        w_next_bit;
    logic              w_baud_done;

    function automatic logic [7:0] f_hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    assign w_baud_done = (r_baud_cnt == BAUD_LAST);
    assign w_next_bit  = r_bit_idx + 3'd1;

    // Select the character currently being framed.
    always_comb begin
        w_cur_char = 8'h0A;
        case (r_char_idx)
            3'd0:    w_cur_char = f_hex_ascii(r_data[15:12]);
            3'd1:    w_cur_char = f_hex_ascii(r_data[11:8]);
            3'd2:    w_cur_char = f_hex_ascii(r_data[7:4]);
            3'd3:    w_cur_char = f_hex_ascii(r_data[3:0]);
            3'd4:    w_cur_char = 8'h0D;
            default: w_cur_char = 8'h0A;
        endcase
    end

    // Next-state logic; w_tx_next is the line level for the cycle after the edge.
    always_comb begin
        w_state_next    = r_state;
        w_baud_cnt_next = r_baud_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_char_idx_next = r_char_idx;
        w_data_next     = r_data;
        w_tx_next       = r_tx;
        w_busy_next     = r_busy;

        unique case (r_state)
            StIdle: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
                if (i_tx_valid) begin
                    w_data_next     = {i_tx_data1, i_tx_data2, i_tx_data3, i_tx_data4};
                    w_state_next    = StStart;
                    w_baud_cnt_next = '0;
                    w_bit_idx_next  = 3'd0;
                    w_char_idx_next = 3'd0;
                    w_tx_next       = 1'b0;
                    w_busy_next     = 1'b1;
                end
            end
            StStart: begin
                if (w_baud_done) begin
                    w_baud_cnt_next = '0;
                    w_bit_idx_next  = 3'd0;
                    w_state_next    = StData;
                    w_tx_next       = w_cur_char[0];
                end else begin
                    w_baud_cnt_next = r_baud_cnt + BAUD_W'(1);
                end
            end
            StData: begin
                if (w_baud_done) begin
                    w_baud_cnt_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = StStop;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_bit_idx_next = w_next_bit;
                        w_tx_next      = w_cur_char[w_next_bit];
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt + BAUD_W'(1);
                end
            end
            StStop: begin
                if (w_baud_done) begin
                    w_baud_cnt_next = '0;
                    if (r_char_idx < LAST_CHAR) begin
                        // Next start bit follows the stop bit with no idle gap.
                        w_char_idx_next = r_char_idx + 3'd1;
                        w_state_next    = StStart;
                        w_tx_next       = 1'b0;
                    end else begin
                        w_char_idx_next = 3'd0;
                        w_state_next    = StIdle;
                        w_tx_next       = 1'b1;
                        w_busy_next     = 1'b0;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_char_idx <= 3'd0;
            r_data     <= 16'h0000;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_char_idx <= w_char_idx_next;
            r_data     <= w_data_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
        end
    end

    assign o_uart_tx = r_tx;
    assign o_tx_busy = r_busy;

endmodule
